// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one single-port SRAM between instruction-fetch and load/store ports
module sram_arbiter #(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int MAX_DSTREAK = 4,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_req,
  input  logic [AW-1:0]    i_addr,
  output logic             i_gnt,
  output logic             i_rvalid,
  output logic [DW-1:0]    i_rdata,
  input  logic             d_req,
  input  logic             d_we,
  input  logic [AW-1:0]    d_addr,
  input  logic [DW-1:0]    d_wdata,
  output logic             d_gnt,
  output logic             d_rvalid,
  output logic [DW-1:0]    d_rdata,
  output logic             sram_en,
  output logic             sram_we,
  output logic [AW-1:0]    sram_addr,
  output logic [DW-1:0]    sram_wdata,
  input  logic [DW-1:0]    sram_rdata,
  input  logic             perf_clr,
  output logic [CNT_W-1:0] i_stall_cnt
);
  localparam int SW = $clog2(MAX_DSTREAK + 1);
  localparam logic [SW-1:0] DMAX = SW'(MAX_DSTREAK);
  logic [SW-1:0] dstreak;
  logic          rv_i;
  logic          rv_d;
  // D wins unless it has already beaten a waiting I MAX_DSTREAK times in a row
  assign i_gnt      = i_req & (~d_req | (dstreak == DMAX));
  assign d_gnt      = d_req & ~i_gnt;
  assign sram_en    = i_gnt | d_gnt;
  assign sram_we    = d_gnt & d_we;
  assign sram_addr  = i_gnt ? i_addr : d_addr;
  assign sram_wdata = d_wdata;
  assign i_rvalid   = rv_i;
  assign d_rvalid   = rv_d;
  assign i_rdata    = sram_rdata;
  assign d_rdata    = sram_rdata;
  // streak tracking and one-cycle read-return flags
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dstreak <= '0;
      rv_i    <= 1'b0;
      rv_d    <= 1'b0;
    end else begin
      dstreak <= (i_gnt | ~i_req) ? '0 : d_gnt ? dstreak + 1'b1 : dstreak;
      rv_i    <= i_gnt;
      rv_d    <= d_gnt & ~d_we;
    end
  end
  // saturating count of cycles I spends waiting; clear wins over a stall
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) i_stall_cnt <= '0;
    else i_stall_cnt <= perf_clr ? '0 : (i_req & ~i_gnt & ~&i_stall_cnt) ? i_stall_cnt + 1'b1 : i_stall_cnt;
  end
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed scoreboard bench for sram_arbiter
module tb_sram_arbiter;
  localparam int CW = 4;
  localparam int SAT = 15;
  logic clk = 1'b0;
  logic reset_n;
  logic i_req, d_req, d_we, perf_clr;
  logic [31:0] i_addr, d_addr, d_wdata, sram_rdata;
  logic i_gnt, i_rvalid, d_gnt, d_rvalid, sram_en, sram_we;
  logic [31:0] i_rdata, d_rdata, sram_addr, sram_wdata;
  logic [CW-1:0] i_stall_cnt;
  typedef struct {logic i; logic d; logic [31:0] data;} rd_t;
  rd_t q[$];
  int ncmp = 0;
  int nfail = 0;
  int mds = 0;
  int mcnt = 0;

  sram_arbiter #(.AW(32), .DW(32), .MAX_DSTREAK(4), .CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata), .perf_clr(perf_clr), .i_stall_cnt(i_stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                      input logic [31:0] da, input logic [31:0] dwd, input logic [31:0] rd,
                      input logic pc);
    rd_t e;
    logic eg, edg;
    @(negedge clk);
    e = '{i: 1'b0, d: 1'b0, data: $urandom};
    if (q.size() > 0) e = q.pop_front();
    sram_rdata = e.data;
    i_req = ir; i_addr = ia; d_req = dr; d_we = dw; d_addr = da; d_wdata = dwd; perf_clr = pc;
    #1;
    eg  = ir & (!dr | (mds == 4));
    edg = dr & !eg;
    chk("i_gnt", {31'b0, i_gnt}, {31'b0, eg});
    chk("d_gnt", {31'b0, d_gnt}, {31'b0, edg});
    chk("sram_en", {31'b0, sram_en}, {31'b0, eg | edg});
    chk("sram_we", {31'b0, sram_we}, {31'b0, edg & dw});
    chk("sram_addr", sram_addr, eg ? ia : da);
    chk("sram_wdata", sram_wdata, dwd);
    chk("i_rvalid", {31'b0, i_rvalid}, {31'b0, e.i});
    chk("d_rvalid", {31'b0, d_rvalid}, {31'b0, e.d});
    if (e.i) chk("i_rdata", i_rdata, e.data);
    if (e.d) chk("d_rdata", d_rdata, e.data);
    chk("i_stall_cnt", {28'b0, i_stall_cnt}, mcnt);
    if (eg || (edg && !dw)) q.push_back('{i: eg, d: edg & !dw, data: rd});
    mcnt = pc ? 0 : (ir && !eg && mcnt != SAT) ? mcnt + 1 : mcnt;
    mds  = (eg || !ir) ? 0 : edg ? mds + 1 : mds;
  endtask

  task automatic idle();
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic rst_mid(input logic exp_i);
    @(negedge clk);
    i_req = 1'b0; d_req = 1'b0; perf_clr = 1'b0;
    #1;
    chk("pre_rst_i_rvalid", {31'b0, i_rvalid}, {31'b0, exp_i});
    chk("pre_rst_d_rvalid", {31'b0, d_rvalid}, {31'b0, !exp_i});
    reset_n = 1'b0;
    #1;
    chk("rst_i_rvalid", {31'b0, i_rvalid}, 32'h0);
    chk("rst_d_rvalid", {31'b0, d_rvalid}, 32'h0);
    chk("rst_cnt", {28'b0, i_stall_cnt}, 32'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    q.delete();
    mds = 0;
    mcnt = 0;
  endtask

  initial begin
    reset_n = 1'b0;
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; perf_clr = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0; sram_rdata = '0;
    repeat (2) @(negedge clk);
    chk("reset_i_rvalid", {31'b0, i_rvalid}, 32'h0);
    chk("reset_d_rvalid", {31'b0, d_rvalid}, 32'h0);
    chk("reset_cnt", {28'b0, i_stall_cnt}, 32'h0);
    reset_n = 1'b1;
    // I-only read
    step(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 32'hDEADBEEF, 1'b0);
    idle();
    // lone D write, no read return
    step(1'b0, 32'h0, 1'b1, 1'b1, 32'h40, 32'h12345678, 32'h0, 1'b0);
    idle();
    // back-to-back D reads
    step(1'b0, 32'h0, 1'b1, 1'b0, 32'h10, 32'h0, 32'hA0A0_0010, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 32'h14, 32'h0, 32'hB0B0_0014, 1'b0);
    idle();
    idle();
    // contention for 12 cycles, one D write in the streak
    for (int k = 0; k < 12; k++)
      step(1'b1, 32'h200 + k, 1'b1, k == 2, 32'h300 + k, 32'h5000 + k, $urandom, 1'b0);
    idle();
    chk("stall_after12", {28'b0, i_stall_cnt}, 32'd10);
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
    idle();
    // saturation then clear during a stall
    for (int k = 0; k < 25; k++)
      step(1'b1, 32'h400 + k, 1'b1, 1'b0, 32'h500 + k, 32'h0, $urandom, 1'b0);
    idle();
    chk("stall_sat", {28'b0, i_stall_cnt}, 32'd15);
    step(1'b1, 32'h600, 1'b1, 1'b0, 32'h604, 32'h0, $urandom, 1'b1);
    idle();
    chk("stall_clr", {28'b0, i_stall_cnt}, 32'd0);
    // reset with a D read in flight and a built-up streak
    for (int k = 0; k < 3; k++)
      step(1'b1, 32'h700, 1'b1, 1'b0, 32'h800 + k, 32'h0, $urandom, 1'b0);
    rst_mid(1'b0);
    for (int k = 0; k < 5; k++)
      step(1'b1, 32'h900, 1'b1, 1'b0, 32'hA00 + k, 32'h0, $urandom, 1'b0);
    idle();
    // reset in the cycle after an I grant
    idle();
    step(1'b1, 32'hB00, 1'b0, 1'b0, 32'h0, 32'h0, 32'h11223344, 1'b0);
    rst_mid(1'b1);
    idle();
    idle();
    chk("post_rst_cnt", {28'b0, i_stall_cnt}, 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
